// File: rtl/alu_control_md.sv
// ALU control with ALUOp/funct decode and an iterative multiply/divide sequencer owning HI/LO.
// Define MULDIV_EN to build the sequencer; without it the muldiv/mf functs decode as illegal.
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       operation,
    output logic             Jr,
    output logic             illegal_op,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

`ifdef MULDIV_EN
    localparam logic MD_ILLEGAL = 1'b0;
`else
    localparam logic MD_ILLEGAL = 1'b1;
`endif

    function automatic logic is_muldiv_f(input logic [5:0] f);
        logic r;
        case (f)
            F_MULT, F_MULTU, F_DIV, F_DIVU: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // ALUOp / funct decode into operation code, Jr and illegal flag
    always_comb begin
        operation  = 4'b0010;
        Jr         = 1'b0;
        illegal_op = 1'b0;
        case (ALUOp)
            3'b000: operation = 4'b0010;
            3'b001: operation = 4'b0110;
            3'b100: operation = 4'b0000;
            3'b101: operation = 4'b0001;
            3'b110: operation = 4'b1100;
            3'b111: operation = 4'b0111;
            3'b011: operation = 4'b1000;
            3'b010: begin
                case (funct)
                    F_ADD:  operation = 4'b0010;
                    F_SUB:  operation = 4'b0110;
                    F_AND:  operation = 4'b0000;
                    F_OR:   operation = 4'b0001;
                    F_XOR:  operation = 4'b1100;
                    F_NOR:  operation = 4'b1011;
                    F_SLT:  operation = 4'b0111;
                    F_SLTU: operation = 4'b1000;
                    F_SLL:  operation = 4'b0101;
                    F_SRL:  operation = 4'b0100;
                    F_SRA:  operation = 4'b0011;
                    F_JR: begin
                        operation = 4'b0010;
                        Jr        = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO: begin
                        operation  = 4'b0010;
                        illegal_op = MD_ILLEGAL;
                    end
                    default: begin
                        operation  = 4'b0010;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            default: operation = 4'b0010;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e          state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   acc_r, acc_s, mq_r, mq_s, mcand_r, mcand_s;
    logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic               is_div_r, is_div_s, neg_q_r, neg_q_s, neg_r_r, neg_r_s;
    logic               div0_r, div0_s, md_done_r, md_done_s;
    logic               is_mf_s, req_md_s, accept_s, signed_op_s, sign_a_s, sign_b_s;
    logic [WIDTH:0]     add_s, rem_sh_s, diff_s;
    logic [2*WIDTH-1:0] prod_s;

    assign is_mf_s  = (funct == F_MFHI) || (funct == F_MFLO);
    assign req_md_s = instr_valid && (ALUOp == 3'b010) && is_muldiv_f(funct);
    assign md_busy  = (state_r != ST_IDLE);
    assign stall    = md_busy && instr_valid && (ALUOp == 3'b010) && (is_muldiv_f(funct) || is_mf_s);
    assign accept_s = (state_r == ST_IDLE) && req_md_s && !stall;

    assign signed_op_s = (funct == F_MULT) || (funct == F_DIV);
    assign sign_a_s    = signed_op_s & op_a[WIDTH-1];
    assign sign_b_s    = signed_op_s & op_b[WIDTH-1];

    // Shift-add multiplies the low register; restoring divide shifts the dividend into the remainder
    assign add_s    = {1'b0, acc_r} + (mq_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    assign rem_sh_s = {acc_r, mq_r[WIDTH-1]};
    assign diff_s   = rem_sh_s - {1'b0, mcand_r};
    assign prod_s   = {acc_r, mq_r};

    // Sequencer next-state and datapath
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        acc_s     = acc_r;
        mq_s      = mq_r;
        mcand_s   = mcand_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        is_div_s  = is_div_r;
        neg_q_s   = neg_q_r;
        neg_r_s   = neg_r_r;
        div0_s    = div0_r;
        md_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s  = ST_RUN;
                    cnt_s    = {CNT_W{1'b0}};
                    acc_s    = {WIDTH{1'b0}};
                    is_div_s = funct[1];
                    mq_s     = sign_a_s ? -op_a : op_a;
                    mcand_s  = sign_b_s ? -op_b : op_b;
                    neg_q_s  = sign_a_s ^ sign_b_s;
                    neg_r_s  = sign_a_s;
                    div0_s   = funct[1] && (op_b == {WIDTH{1'b0}});
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_div_r) begin
                    if (!diff_s[WIDTH]) begin
                        acc_s = diff_s[WIDTH-1:0];
                        mq_s  = {mq_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_s = rem_sh_s[WIDTH-1:0];
                        mq_s  = {mq_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_s = add_s[WIDTH:1];
                    mq_s  = {add_s[0], mq_r[WIDTH-1:1]};
                end
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_s   = ST_IDLE;
                md_done_s = 1'b1;
                // Divide by zero keeps the raw all-ones quotient and unsigned dividend
                if (is_div_r) begin
                    lo_s = (neg_q_r && !div0_r) ? -mq_r : mq_r;
                    hi_s = (neg_r_r && !div0_r) ? -acc_r : acc_r;
                end else begin
                    {hi_s, lo_s} = neg_q_r ? -prod_s : prod_s;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer and HI/LO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            mq_r      <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            div0_r    <= 1'b0;
            md_done_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            acc_r     <= acc_s;
            mq_r      <= mq_s;
            mcand_r   <= mcand_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            is_div_r  <= is_div_s;
            neg_q_r   <= neg_q_s;
            neg_r_r   <= neg_r_s;
            div0_r    <= div0_s;
            md_done_r <= md_done_s;
        end
    end

    assign md_done = md_done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

    // mfhi/mflo writeback select
    always_comb begin
        mf_result = {WIDTH{1'b0}};
        if (funct == F_MFHI) begin
            mf_result = hi_r;
        end else if (funct == F_MFLO) begin
            mf_result = lo_r;
        end else begin
            mf_result = {WIDTH{1'b0}};
        end
    end
`else
    logic unused_s;

    assign unused_s  = ^{clk, rst_n, instr_valid, op_a, op_b};
    assign stall     = 1'b0;
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign hi        = {WIDTH{1'b0}};
    assign lo        = {WIDTH{1'b0}};
    assign mf_result = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu_control_md.sv
// Directed self-checking bench for alu_control_md (WIDTH=32); sequencer checks follow MULDIV_EN.
module tb_alu_control_md;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic [3:0]  operation;
    logic        Jr, illegal_op, stall, md_busy, md_done;
    logic [31:0] hi, lo, mf_result;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc;

`ifdef MULDIV_EN
    localparam logic MD_ILL = 1'b0;
`else
    localparam logic MD_ILL = 1'b1;
`endif

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic [5:0] fn_tab  [19] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                 6'b000011, 6'b001000, 6'b011000, 6'b011001, 6'b011010,
                                 6'b011011, 6'b010000, 6'b010010, 6'b111111};
    logic [3:0] op_tab  [19] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
                                 4'b1011, 4'b0111, 4'b1000, 4'b0101, 4'b0100,
                                 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    logic       jr_tab  [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ill_tab [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, MD_ILL, MD_ILL, MD_ILL, MD_ILL, MD_ILL, MD_ILL, 1'b1};
    logic [2:0] aop_tab [7]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011};
    logic [3:0] aexp_tab[7]  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1000};

    alu_control_md #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .ALUOp(ALUOp), .funct(funct),
        .op_a(op_a), .op_b(op_b), .operation(operation), .Jr(Jr), .illegal_op(illegal_op),
        .stall(stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo),
        .mf_result(mf_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr_valid = 1'b1; ALUOp = 3'b010; funct = f; op_a = a; op_b = b;
        #1 check("issue_stall", {31'd0, stall}, 32'd0);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            @(negedge clk);
            instr_valid = 1'b0; ALUOp = 3'b000; funct = 6'd0;
            c++;
            #1;
            if (c == 1) check("busy_n1", {31'd0, md_busy}, 32'd1);
        end while (md_done !== 1'b1 && c < 100);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; ALUOp = 3'b000; funct = 6'd0;
        op_a = 32'd0; op_b = 32'd0;
        #7;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_done", {31'd0, md_done}, 32'd0);
        check("rst_op", {28'd0, operation}, 32'h2);
        check("rst_jr", {31'd0, Jr}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // R-type decode sweep with instr_valid low so nothing starts
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            ALUOp = 3'b010; funct = fn_tab[i];
            #1;
            check($sformatf("rop_%b", fn_tab[i]), {28'd0, operation}, {28'd0, op_tab[i]});
            check($sformatf("rjr_%b", fn_tab[i]), {31'd0, Jr}, {31'd0, jr_tab[i]});
            check($sformatf("rill_%b", fn_tab[i]), {31'd0, illegal_op}, {31'd0, ill_tab[i]});
        end
        // Non-R ALUOps with the jr funct present: Jr must stay low
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ALUOp = aop_tab[i]; funct = 6'b001000;
            #1;
            check($sformatf("aop_%b", aop_tab[i]), {28'd0, operation}, {28'd0, aexp_tab[i]});
            check($sformatf("ajr_%b", aop_tab[i]), {31'd0, Jr}, 32'd0);
        end

`ifdef MULDIV_EN
        issue(F_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(cyc);
        check("mult_lat", cyc, 32'd34);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        check("mult_busy_end", {31'd0, md_busy}, 32'd0);
        @(negedge clk) #1 check("done_pulse", {31'd0, md_done}, 32'd0);

        issue(F_MULTU, 32'hFFFFFFFD, 32'd7);
        wait_done(cyc);
        check("multu_lat", cyc, 32'd34);
        check("multu_hi", hi, 32'h00000006);
        check("multu_lo", lo, 32'hFFFFFFEB);

        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        check("div_lat", cyc, 32'd34);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(F_DIVU, 32'd100, 32'd0);
        wait_done(cyc);
        check("divu0_lat", cyc, 32'd34);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd100);

        issue(F_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // Hazards: independent add, rejected muldiv, then mflo held until the result lands
        issue(F_MULT, 32'd3, 32'd5);
        @(negedge clk);
        funct = F_ADD;
        #1 check("add_busy_stall", {31'd0, stall}, 32'd0);
        check("add_busy", {31'd0, md_busy}, 32'd1);
        @(negedge clk);
        funct = F_MULTU; op_a = 32'd9; op_b = 32'd9;
        #1 check("md_busy_stall", {31'd0, stall}, 32'd1);
        cyc = 2;
        do begin
            @(negedge clk);
            funct = F_MFLO;
            cyc++;
            #1;
        end while (stall === 1'b1 && cyc < 100);
        check("mflo_release", cyc, 32'd34);
        check("mflo_done", {31'd0, md_done}, 32'd1);
        check("mflo_val", mf_result, 32'd15);
        funct = F_MFHI;
        #1 check("mfhi_val", mf_result, 32'd0);
        // Back-to-back: next mult presented in the md_done cycle
        funct = F_MULT; op_a = 32'd6; op_b = 32'd7;
        #1 check("b2b_stall", {31'd0, stall}, 32'd0);
        wait_done(cyc);
        check("b2b_lat", cyc, 32'd34);
        check("b2b_lo", lo, 32'd42);
        check("b2b_hi", hi, 32'd0);

        // Abort mid-run with an asynchronous reset
        issue(F_MULT, 32'd3, 32'd5);
        repeat (10) begin
            @(negedge clk);
            instr_valid = 1'b0; funct = 6'd0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_hi", hi, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        issue(F_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(cyc);
        check("post_abort_lat", cyc, 32'd34);
        check("post_abort_hi", hi, 32'hFFFFFFFF);
        check("post_abort_lo", lo, 32'hFFFFFFEB);
`else
        @(negedge clk);
        instr_valid = 1'b1; ALUOp = 3'b010; funct = F_MULT; op_a = 32'd3; op_b = 32'd5;
        #1 check("nomd_stall", {31'd0, stall}, 32'd0);
        check("nomd_ill", {31'd0, illegal_op}, 32'd1);
        repeat (3) @(negedge clk);
        funct = F_MFLO;
        #1 check("nomd_busy", {31'd0, md_busy}, 32'd0);
        check("nomd_done", {31'd0, md_done}, 32'd0);
        check("nomd_hi", hi, 32'd0);
        check("nomd_lo", lo, 32'd0);
        check("nomd_mf", mf_result, 32'd0);
        check("nomd_mf_stall", {31'd0, stall}, 32'd0);
        instr_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
